h2f_lw_timer: RTL and testbench

- Avalon-MM slave interval timer on the HPS lightweight H2F bridge, clocked by fpga_clk_50 from the FPGA PLL.
- Provides a prescaled down-counter with one-shot and auto-reload modes, a level interrupt to the HPS F2H IRQ input, and an optional PWM output.
- In the top level, rst is driven by the inverted HPS h2f reset, synchronised to fpga_clk_50.

---
 rtl/h2f_lw_timer_if.sv | 27 ++
 rtl/h2f_lw_timer.sv | 235 +++++++++++++++++++++++
 tb/tb_h2f_lw_timer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/h2f_lw_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : h2f_lw_timer_if
// Brief    : Avalon-MM slave bus bundle for the lightweight H2F interval timer.
// Revision : 1.0 - initial release
// ============================================================================
interface h2f_lw_timer_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        input  avs_readdata, avs_readdatavalid, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
        output avs_readdata, avs_readdatavalid, avs_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/h2f_lw_timer.sv
`default_nettype none
// ============================================================================
// Module   : h2f_lw_timer
// Brief    : Avalon-MM interval timer with prescaler, one-shot / auto-reload
//            modes and a level interrupt. Define TIMER_PWM_OUT_EN to build the
//            COMPARE register and the registered pwm_out output.
// Revision : 1.0 - initial release
// ============================================================================
module h2f_lw_timer #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRESCALE_W   = 16,
    parameter logic [31:0] RESET_PERIOD = 32'd49999999
) (
    input  wire logic     fpga_clk_50,
    input  wire logic     rst,
    h2f_lw_timer_if.slave avs,
    output logic          irq
`ifdef TIMER_PWM_OUT_EN
    ,
    output logic          pwm_out
`endif
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_PRESCALE = 3'd3;
    localparam logic [2:0] ADDR_COUNT    = 3'd4;
    localparam logic [2:0] ADDR_COMPARE  = 3'd5;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CNT_W-1:0] PERIOD_RST = RESET_PERIOD[CNT_W-1:0];

    // Merge new write data into an old register value, one byte lane at a time.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [0:0]            state;
    logic [0:0]            state_nxt;
    logic                  run;
    logic                  ctrl_cont;
    logic                  ctrl_irq_en;
    logic                  to_flag;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      period;
    logic [PRESCALE_W-1:0] prescaler;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           readdata;
    logic                  readdatavalid;
    logic [31:0]           rd_mux;
    logic [31:0]           compare_rd;

    logic wr_ctrl;
    logic wr_status;
    logic wr_period;
    logic wr_prescale;
    logic start_req;
    logic stop_req;
    logic tick;
    logic timeout;

    // CTRL and STATUS only react to byte lane 0.
    assign wr_ctrl     = avs.avs_write && (avs.avs_address == ADDR_CTRL) && avs.avs_byteenable[0];
    assign wr_status   = avs.avs_write && (avs.avs_address == ADDR_STATUS) && avs.avs_byteenable[0];
    assign wr_period   = avs.avs_write && (avs.avs_address == ADDR_PERIOD);
    assign wr_prescale = avs.avs_write && (avs.avs_address == ADDR_PRESCALE);

    // STOP dominates START when both are written together.
    assign start_req = wr_ctrl && avs.avs_writedata[2] && !avs.avs_writedata[3];
    assign stop_req  = wr_ctrl && avs.avs_writedata[3];

    // A START or STOP on this edge overrides any tick that would have happened.
    assign tick    = run && (prescaler == prescale) && !start_req && !stop_req;
    assign timeout = tick && (count == '0);

    // Run/idle state register.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Run/idle next-state: START enters or restarts, STOP or one-shot timeout leaves.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_req) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_req) begin
                    state_nxt = ST_IDLE;
                end else if (timeout && !ctrl_cont) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Run/idle outputs.
    always_comb begin
        run = (state == ST_RUN);
    end

    // Down-counter and prescaler; both freeze while idle.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            count     <= '0;
            prescaler <= '0;
        end else if (start_req) begin
            count     <= period;
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end else if (ctrl_cont) begin
                count <= period;
            end
        end else if (run && !stop_req) begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

    // Control bits and sticky timeout flag; a timeout beats a same-cycle clear.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            ctrl_cont   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            to_flag     <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                ctrl_cont   <= avs.avs_writedata[0];
                ctrl_irq_en <= avs.avs_writedata[1];
            end
            if (timeout) begin
                to_flag <= 1'b1;
            end else if (wr_status && avs.avs_writedata[0]) begin
                to_flag <= 1'b0;
            end
        end
    end

    // PERIOD and PRESCALE with per-byte write enables.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            period   <= PERIOD_RST;
            prescale <= '0;
        end else begin
            if (wr_period) begin
                period <= CNT_W'(merge_bytes(32'(period), avs.avs_writedata, avs.avs_byteenable));
            end
            if (wr_prescale) begin
                prescale <= PRESCALE_W'(merge_bytes(32'(prescale), avs.avs_writedata,
                                                    avs.avs_byteenable));
            end
        end
    end

`ifdef TIMER_PWM_OUT_EN
    logic [CNT_W-1:0] compare;
    logic             wr_compare;

    assign wr_compare = avs.avs_write && (avs.avs_address == ADDR_COMPARE);
    assign compare_rd = 32'(compare);

    // COMPARE register with per-byte write enables.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            compare <= '0;
        end else if (wr_compare) begin
            compare <= CNT_W'(merge_bytes(32'(compare), avs.avs_writedata, avs.avs_byteenable));
        end
    end

    // PWM is high while running and the counter sits below COMPARE.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            pwm_out <= 1'b0;
        end else begin
            pwm_out <= run && (count < compare);
        end
    end
`else
    assign compare_rd = '0;
`endif

    // Read mux; START/STOP are pulses and read back as 0.
    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_CTRL:     rd_mux = {30'd0, ctrl_irq_en, ctrl_cont};
            ADDR_STATUS:   rd_mux = {30'd0, run, to_flag};
            ADDR_PERIOD:   rd_mux = 32'(period);
            ADDR_PRESCALE: rd_mux = 32'(prescale);
            ADDR_COUNT:    rd_mux = 32'(count);
            ADDR_COMPARE:  rd_mux = compare_rd;
            default:       rd_mux = '0;
        endcase
    end

    // Fixed one-cycle read latency; data holds until the next read.
    always_ff @(posedge fpga_clk_50) begin
        if (rst) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= avs.avs_read;
            if (avs.avs_read) begin
                readdata <= rd_mux;
            end
        end
    end

    assign avs.avs_readdata      = readdata;
    assign avs.avs_readdatavalid = readdatavalid;
    assign avs.avs_waitrequest   = 1'b0;
    assign irq                   = to_flag & ctrl_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_h2f_lw_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_h2f_lw_timer
// Brief    : Self-checking bench for h2f_lw_timer with an arithmetic timing
//            model and a byte-lane shadow register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_h2f_lw_timer;

    localparam logic [2:0] A_CTRL = 3'd0, A_STATUS = 3'd1, A_PERIOD = 3'd2;
    localparam logic [2:0] A_PRESC = 3'd3, A_COUNT = 3'd4, A_COMPARE = 3'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        irq;
    int unsigned cyc = 0;
    int unsigned last_edge = 0;
    int          checks = 0;
    int          errors = 0;
`ifdef TIMER_PWM_OUT_EN
    logic        pwm_out;
`endif

    h2f_lw_timer_if bus ();

    h2f_lw_timer dut (
        .fpga_clk_50 (clk),
        .rst         (rst),
        .avs         (bus),
        .irq         (irq)
`ifdef TIMER_PWM_OUT_EN
        ,
        .pwm_out     (pwm_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus helpers (stimulus only) ----------------
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_writedata = d; bus.avs_byteenable = be; bus.avs_write = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0;
        last_edge = cyc;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
        @(posedge clk); #1;
        bus.avs_address = a; bus.avs_read = 1'b1;
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        v = bus.avs_readdatavalid;
        d = bus.avs_readdata;
    endtask

    // Wait until irq is seen high; returns edges since e0, or -1 if the budget runs out.
    task automatic wait_irq(input int unsigned e0, input int budget, output int d);
        d = -1;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk); #1;
            if (irq === 1'b1) begin
                d = int'(cyc - e0);
                break;
            end
        end
    endtask

    // Stop the timer and clear TO so a test starts from a quiet state.
    task automatic quiesce();
        bus_write(A_CTRL, 32'h8, 4'h1);
        bus_write(A_STATUS, 32'h1, 4'h1);
    endtask

    // Counter value after d edges from START, derived from tick arithmetic.
    function automatic int unsigned count_model(int unsigned p, int unsigned s, bit cont,
                                                int unsigned d);
        int unsigned t;
        t = d / (s + 1);
        if (cont) return p - (t % (p + 1));
        return (t >= p) ? 0 : p - t;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [2:0]  addr [4];
        logic [31:0] expv [4];
        addr = '{A_CTRL, A_STATUS, A_PERIOD, A_PRESC};
        expv = '{32'h0, 32'h0, 32'h02FAF07F, 32'h0};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++;
        if (bus.avs_readdatavalid !== 1'b0 || bus.avs_readdata !== 32'h0 || bus.avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL reset_bus got vld=%b data=%h wait=%b exp 0/0/0",
                     bus.avs_readdatavalid, bus.avs_readdata, bus.avs_waitrequest);
        end
        for (int i = 0; i < 4; i++) begin
            bus_read(addr[i], d, v);
            checks++;
            if (v !== 1'b1 || d !== expv[i]) begin
                errors++;
                $display("FAIL reset_read addr=%0d got vld=%b data=%h exp vld=1 data=%h", addr[i], v, d, expv[i]);
            end
        end
        @(posedge clk); #1;
        checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL read_valid_width got=%b exp=0", bus.avs_readdatavalid);
        end
    endtask

    task automatic test_auto_reload();
        int          d;
        int unsigned e0;
        logic [31:0] r;
        logic        v;
        quiesce();
        bus_write(A_PERIOD, 32'd4, 4'hF);
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'h1);
        e0 = last_edge;
        wait_irq(e0, 40, d);
        checks++;
        if (d != 5) begin errors++; $display("FAIL reload_first_to got=%0d exp=5", d); end
        bus_write(A_STATUS, 32'h1, 4'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL reload_clear got irq=%b exp=0", irq); end
        wait_irq(e0, 40, d);
        checks++;
        if (d != 10) begin errors++; $display("FAIL reload_second_to got=%0d exp=10", d); end
        bus_read(A_STATUS, r, v);
        checks++;
        if (r !== 32'h3) begin errors++; $display("FAIL reload_status got=%h exp=3", r); end
        // Dropping IRQ_EN masks irq but leaves TO set.
        bus_write(A_CTRL, 32'h1, 4'h1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask got irq=%b exp=0", irq); end
        bus_read(A_STATUS, r, v);
        checks++;
        if (r[0] !== 1'b1) begin errors++; $display("FAIL irq_mask_to got=%b exp=1", r[0]); end
    endtask

    task automatic test_oneshot_prescale();
        int          d;
        int unsigned e0;
        logic [31:0] r;
        logic        v;
        quiesce();
        bus_write(A_PERIOD, 32'd3, 4'hF);
        bus_write(A_PRESC, 32'd2, 4'hF);
        bus_write(A_CTRL, 32'h6, 4'h1);
        e0 = last_edge;
        wait_irq(e0, 60, d);
        checks++;
        if (d != 12) begin errors++; $display("FAIL oneshot_to got=%0d exp=12", d); end
        bus_read(A_STATUS, r, v);
        checks++;
        if (r !== 32'h1) begin errors++; $display("FAIL oneshot_status got=%h exp=1", r); end
        repeat (6) @(posedge clk);
        bus_read(A_COUNT, r, v);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL oneshot_count got=%h exp=0", r); end
    endtask

    task automatic test_random_timing();
        int unsigned p, s, len, e0, es, d, expc;
        bit          cont;
        logic [31:0] r;
        logic        v;
        for (int it = 0; it < 8; it++) begin
            p    = $urandom_range(0, 6);
            s    = $urandom_range(0, 3);
            cont = 1'($urandom_range(0, 1));
            len  = (p + 1) * (s + 1);
            quiesce();
            bus_write(A_PERIOD, p, 4'hF);
            bus_write(A_PRESC, s, 4'hF);
            bus_write(A_CTRL, 32'h6 | 32'(cont), 4'h1);
            e0 = last_edge;
            d  = 0;
            while (d < 2 * len + 1) begin
                @(posedge clk); #1;
                d = cyc - e0;
                checks++;
                if (irq !== (d >= len)) begin
                    errors++;
                    $display("FAIL rand_irq it=%0d p=%0d s=%0d d=%0d got=%b exp=%b", it, p, s, d, irq, d >= len);
                end
            end
            if (cont) begin
                bus_write(A_CTRL, 32'h8, 4'h1);
                es   = last_edge;
                expc = count_model(p, s, 1'b1, es - 1 - e0);
            end else begin
                expc = 0;
            end
            repeat (2) @(posedge clk);
            bus_read(A_COUNT, r, v);
            checks++;
            if (r !== expc) begin
                errors++; $display("FAIL rand_count it=%0d cont=%0d got=%0d exp=%0d", it, cont, r, expc);
            end
            bus_read(A_STATUS, r, v);
            checks++;
            if (r !== 32'h1) begin errors++; $display("FAIL rand_status it=%0d got=%h exp=1", it, r); end
        end
    endtask

    task automatic test_collisions();
        int unsigned e0, es, expc;
        logic [31:0] r;
        logic        v;
        int          guard;
        // TO clear landing on the timeout edge: set wins.
        quiesce();
        bus_write(A_PERIOD, 32'd4, 4'hF);
        bus_write(A_PRESC, 32'd0, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'h1);
        e0 = last_edge;
        guard = 0;
        while (cyc - e0 < 6 && guard < 20) begin @(posedge clk); #1; guard++; end
        bus_write(A_STATUS, 32'h1, 4'h1);
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0 || cyc - e0 != 9) begin
            errors++; $display("FAIL clr_pre got irq=%b d=%0d exp irq=0 d=9", irq, cyc - e0);
        end
        bus.avs_address = A_STATUS; bus.avs_writedata = 32'h1; bus.avs_byteenable = 4'h1; bus.avs_write = 1'b1;
        @(posedge clk); #1;
        bus.avs_write = 1'b0;
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL clr_vs_set got irq=%b exp=1", irq); end
        // STOP mid-count freezes the counter.
        quiesce();
        bus_write(A_PERIOD, 32'd100, 4'hF);
        bus_write(A_CTRL, 32'h4, 4'h1);
        e0 = last_edge;
        repeat (7) @(posedge clk);
        bus_write(A_CTRL, 32'h8, 4'h1);
        es   = last_edge;
        expc = 100 - (es - 1 - e0);
        bus_read(A_COUNT, r, v);
        checks++;
        if (r !== expc) begin errors++; $display("FAIL stop_freeze got=%0d exp=%0d", r, expc); end
        // START together with STOP: stays stopped, no reload.
        bus_write(A_CTRL, 32'hC, 4'h1);
        repeat (4) @(posedge clk);
        bus_read(A_STATUS, r, v);
        checks++;
        if (r[1] !== 1'b0) begin errors++; $display("FAIL start_stop_run got=%b exp=0", r[1]); end
        bus_read(A_COUNT, r, v);
        checks++;
        if (r !== expc) begin errors++; $display("FAIL start_stop_count got=%0d exp=%0d", r, expc); end
        // COUNT is read-only.
        bus_write(A_COUNT, 32'h123, 4'hF);
        bus_read(A_COUNT, r, v);
        checks++;
        if (r !== expc) begin errors++; $display("FAIL count_ro got=%0d exp=%0d", r, expc); end
    endtask

    task automatic test_bus_corners();
        logic [31:0] r;
        logic        v;
        bus_write(A_PERIOD, 32'h11223344, 4'hF);
        bus_write(A_PERIOD, 32'hAABBCCDD, 4'h3);
        bus_read(A_PERIOD, r, v);
        checks++;
        if (r !== 32'h1122CCDD) begin errors++; $display("FAIL byte_lanes got=%h exp=1122ccdd", r); end
        // Read and write together: the read sees the old value.
        @(posedge clk); #1;
        bus.avs_address = A_PERIOD; bus.avs_writedata = 32'h55667788; bus.avs_byteenable = 4'hF;
        bus.avs_read = 1'b1; bus.avs_write = 1'b1;
        @(posedge clk); #1;
        bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        checks++;
        if (bus.avs_readdatavalid !== 1'b1 || bus.avs_readdata !== 32'h1122CCDD) begin
            errors++;
            $display("FAIL rw_same got vld=%b data=%h exp vld=1 data=1122ccdd", bus.avs_readdatavalid, bus.avs_readdata);
        end
        bus_read(A_PERIOD, r, v);
        checks++;
        if (r !== 32'h55667788) begin errors++; $display("FAIL rw_after got=%h exp=55667788", r); end
        bus_write(3'd6, 32'hFFFFFFFF, 4'hF);
        bus_read(3'd6, r, v);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL addr6 got=%h exp=0", r); end
        bus_read(3'd7, r, v);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL addr7 got=%h exp=0", r); end
        // Reset arriving with a pending read drops the response.
        @(posedge clk); #1;
        bus.avs_address = A_PERIOD; bus.avs_read = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        bus.avs_read = 1'b0;
        checks++;
        if (bus.avs_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL rst_read got vld=%b exp=0", bus.avs_readdatavalid);
        end
        rst = 1'b0;
        bus_read(A_PERIOD, r, v);
        checks++;
        if (r !== 32'h02FAF07F) begin errors++; $display("FAIL rst_period got=%h exp=02faf07f", r); end
    endtask

    task automatic test_random_regs();
        logic [31:0] sh [3];
        logic [31:0] mask [3];
        logic [2:0]  addr [3];
        logic [31:0] d, r;
        logic [3:0]  be;
        logic        v;
        int          k;
        addr = '{A_PERIOD, A_PRESC, A_COMPARE};
        mask = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF};
        for (int i = 0; i < 3; i++) begin
            bus_write(addr[i], 32'h0, 4'hF);
            sh[i] = 32'h0;
        end
        for (int it = 0; it < 12; it++) begin
            k  = $urandom_range(0, 2);
            d  = $urandom;
            be = 4'($urandom_range(0, 15));
            bus_write(addr[k], d, be);
            for (int b = 0; b < 4; b++) if (be[b]) sh[k][8*b +: 8] = d[8*b +: 8];
            sh[k] = sh[k] & mask[k];
`ifndef TIMER_PWM_OUT_EN
            sh[2] = 32'h0;
`endif
            bus_read(addr[k], r, v);
            checks++;
            if (r !== sh[k] || v !== 1'b1) begin
                errors++; $display("FAIL rand_reg addr=%0d be=%h got=%h exp=%h", addr[k], be, r, sh[k]);
            end
        end
    endtask

    task automatic test_compare();
        logic [31:0] r;
        logic        v;
        quiesce();
`ifdef TIMER_PWM_OUT_EN
        begin
            int highs;
            bus_write(A_PERIOD, 32'd9, 4'hF);
            bus_write(A_PRESC, 32'd0, 4'hF);
            bus_write(A_COMPARE, 32'd5, 4'hF);
            bus_write(A_CTRL, 32'h5, 4'h1);
            repeat (3) @(posedge clk);
            highs = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (pwm_out === 1'b1) highs++;
            end
            checks++;
            if (highs != 10) begin errors++; $display("FAIL pwm_duty got=%0d exp=10", highs); end
            bus_write(A_CTRL, 32'h8, 4'h1);
            repeat (2) @(posedge clk); #1;
            checks++;
            if (pwm_out !== 1'b0) begin errors++; $display("FAIL pwm_stopped got=%b exp=0", pwm_out); end
        end
`else
        bus_write(A_COMPARE, 32'd5, 4'hF);
        bus_read(A_COMPARE, r, v);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL compare_absent got=%h exp=0", r); end
`endif
        bus_read(A_CTRL, r, v);
        checks++;
        if (r[1:0] !== 2'b01 && r[1:0] !== 2'b00) begin
            errors++; $display("FAIL ctrl_readback got=%h exp CONT-only", r);
        end
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
        bus.avs_writedata = '0; bus.avs_byteenable = '0;
        test_reset();
        test_auto_reload();
        test_oneshot_prescale();
        test_random_timing();
        test_collisions();
        test_bus_corners();
        test_random_regs();
        test_compare();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
